// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: merges a single-cycle ALU result stream with a
// buffered mem/multi-cycle result FIFO onto the single RF write port. An accepted ALU write
// kills older queued writes to the same register, so the ALU value is the one that remains in
// the register file.
// Optional build macro RF_FWD_EN: when defined, the rs/rt forwarding lookup is present. When it
// is undefined, the lookup outputs are tied to zero and the lookup ports are left unused.
module rf_writeback_ctrl #(
    parameter int unsigned ADDR  = 5,
    parameter int unsigned BUS_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     reloj_cucu,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR-1:0]          alu_addr,
    input  logic [BUS_W-1:0]         alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR-1:0]          mem_addr,
    input  logic [BUS_W-1:0]         mem_data,
    output logic                     r_write,
    output logic [ADDR-1:0]          rd_addr,
    output logic [BUS_W-1:0]         rd_w_data,
    input  logic [ADDR-1:0]          rs_addr,
    output logic                     rs_hit,
    output logic [BUS_W-1:0]         rs_fwd,
    input  logic [ADDR-1:0]          rt_addr,
    output logic                     rt_hit,
    output logic [BUS_W-1:0]         rt_fwd,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] live_q, live_d;
    logic [ADDR-1:0]  addr_q [DEPTH];
    logic [BUS_W-1:0] data_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             r_write_q, r_write_d;
    logic [ADDR-1:0]  rd_addr_q, rd_addr_d;
    logic [BUS_W-1:0] rd_data_q, rd_data_d;

    logic push, pop, alu_wr;

    // mem_ready looks only at the registered count, so a same-cycle pop never frees a full FIFO
    assign mem_ready = (count_q < CW'(DEPTH));
    assign push      = mem_valid && mem_ready;
    assign alu_wr    = alu_valid && (alu_addr != '0);
    assign pop       = !alu_wr && (count_q != '0);

    assign r_write    = r_write_q;
    assign rd_addr    = rd_addr_q;
    assign rd_w_data  = rd_data_q;
    assign fifo_count = count_q;

    // Next-state for FIFO bookkeeping: kill older same-address entries, retire head, append tail
    always_comb begin
        live_d   = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (alu_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == alu_addr) live_d[i] = 1'b0;
            end
        end
        // Clearing live on pop keeps live implying occupied
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end
        // Applied after the kill so a same-cycle push is treated as younger than the ALU write
        if (push) begin
            live_d[wr_ptr_q] = (mem_addr != '0);
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state for the registered write port: ALU first, then FIFO head, else idle
    always_comb begin
        r_write_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (alu_wr) begin
            r_write_d = 1'b1;
            rd_addr_d = alu_addr;
            rd_data_d = alu_data;
        end else if (pop) begin
            r_write_d = live_q[rd_ptr_q];
            rd_addr_d = addr_q[rd_ptr_q];
            rd_data_d = data_q[rd_ptr_q];
        end
    end

    // Control state with synchronous reset; queued entries are dropped without a write
    always_ff @(posedge reloj_cucu) begin
        if (reset) begin
            live_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            r_write_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            live_q    <= live_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            r_write_q <= r_write_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // FIFO payload storage; contents are meaningless unless the slot is occupied
    always_ff @(posedge reloj_cucu) begin
        if (push) begin
            addr_q[wr_ptr_q] <= mem_addr;
            data_q[wr_ptr_q] <= mem_data;
        end
    end

`ifdef RF_FWD_EN
    logic [ADDR-1:0]  lk_addr [2];
    logic             lk_hit  [2];
    logic [BUS_W-1:0] lk_data [2];
    logic [PW-1:0]    idx;

    assign lk_addr[0] = rs_addr;
    assign lk_addr[1] = rt_addr;

    // Forwarding search: output register is oldest, then FIFO scanned head to tail so the
    // youngest live match wins
    always_comb begin
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            lk_hit[p]  = 1'b0;
            lk_data[p] = '0;
            if (r_write_q && (rd_addr_q == lk_addr[p])) begin
                lk_hit[p]  = 1'b1;
                lk_data[p] = rd_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr_q + PW'(k);
                if ((CW'(k) < count_q) && live_q[idx] && (addr_q[idx] == lk_addr[p])) begin
                    lk_hit[p]  = 1'b1;
                    lk_data[p] = data_q[idx];
                end
            end
            if (lk_addr[p] == '0) begin
                lk_hit[p]  = 1'b0;
                lk_data[p] = '0;
            end
        end
    end

    assign rs_hit = lk_hit[0];
    assign rs_fwd = lk_data[0];
    assign rt_hit = lk_hit[1];
    assign rt_fwd = lk_data[1];
`else
    logic unused_lookup;
    assign unused_lookup = ^{rs_addr, rt_addr};
    assign rs_hit = 1'b0;
    assign rs_fwd = '0;
    assign rt_hit = 1'b0;
    assign rt_fwd = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl with a scoreboard of expected RF writes in commit order.
module tb_rf_writeback_ctrl;

`ifdef RF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, mem_ready;
    logic [4:0]  alu_addr, mem_addr, rd_addr, rs_addr, rt_addr;
    logic [31:0] alu_data, mem_data, rd_w_data, rs_fwd, rt_fwd;
    logic        r_write, rs_hit, rt_hit;
    logic [2:0]  fifo_count;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.ADDR(5), .BUS_W(32), .DEPTH(4)) dut (
        .reloj_cucu (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .r_write    (r_write),
        .rd_addr    (rd_addr),
        .rd_w_data  (rd_w_data),
        .rs_addr    (rs_addr),
        .rs_hit     (rs_hit),
        .rs_fwd     (rs_fwd),
        .rt_addr    (rt_addr),
        .rt_hit     (rt_hit),
        .rt_fwd     (rt_fwd),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] a, input logic [31:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_data  = d;
    endtask

    // Advance one edge, then score any write the DUT issued against the queue head
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (r_write === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_write", 32'(rd_addr), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(rd_addr), 32'(e.a));
                chk("wr_data", rd_w_data, e.d);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        alu(1'b0, 5'd0, 32'h0);
        mem(1'b0, 5'd0, 32'h0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;

        // Reset state
        tick();
        tick();
        chk("rst_r_write", 32'(r_write), 32'h0);
        chk("rst_rd_addr", 32'(rd_addr), 32'h0);
        chk("rst_rd_data", rd_w_data, 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_rs_hit", 32'(rs_hit), 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_mem_ready", 32'(mem_ready), 32'h1);

        // Single ALU write, one-cycle latency
        alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        tick();
        chk("alu_r_write", 32'(r_write), 32'h1);

        // Fill the FIFO while the ALU holds the port
        for (int i = 0; i < 4; i++) begin
            chk("fill_mem_ready", 32'(mem_ready), 32'h1);
            alu(1'b1, 5'd9, 32'h0990_0000 + 32'(i));
            mem(1'b1, 5'(i + 1), 32'h11 * 32'(i + 1));
            expect_wr(5'd9, 32'h0990_0000 + 32'(i));
            tick();
        end
        chk("full_mem_ready", 32'(mem_ready), 32'h0);
        chk("full_count", 32'(fifo_count), 32'h4);
        alu(1'b1, 5'd9, 32'h0990_00FF);
        mem(1'b1, 5'd8, 32'h88);
        expect_wr(5'd9, 32'h0990_00FF);
        tick();
        chk("full_no_push", 32'(fifo_count), 32'h4);
        alu(1'b0, 5'd0, 32'h0);
        mem(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'h11 * 32'(i + 1));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_r_write", 32'(r_write), 32'h1);
            chk("drain_count", 32'(fifo_count), 32'(3 - i));
        end
        tick();
        chk("drain_idle", 32'(r_write), 32'h0);
        chk("drain_sb_empty", 32'(sb.size()), 32'h0);

        // ALU write kills an older queued write to the same register
        mem(1'b1, 5'd7, 32'h70);
        tick();
        chk("kill_push_count", 32'(fifo_count), 32'h1);
        mem(1'b0, 5'd0, 32'h0);
        alu(1'b1, 5'd7, 32'h99);
        expect_wr(5'd7, 32'h99);
        tick();
        chk("kill_no_pop", 32'(fifo_count), 32'h1);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("killed_pop_r_write", 32'(r_write), 32'h0);
        chk("killed_pop_count", 32'(fifo_count), 32'h0);

        // Same-cycle push and ALU write: the pushed entry is younger and survives
        mem(1'b1, 5'd6, 32'h60);
        alu(1'b1, 5'd6, 32'h61);
        expect_wr(5'd6, 32'h61);
        tick();
        mem(1'b0, 5'd0, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        expect_wr(5'd6, 32'h60);
        tick();
        chk("same_cycle_survivor", 32'(r_write), 32'h1);

        // Forwarding lookups with two queued writes to r3
        alu(1'b1, 5'd10, 32'hA0);
        mem(1'b1, 5'd3, 32'h30);
        expect_wr(5'd10, 32'hA0);
        tick();
        alu(1'b1, 5'd10, 32'hA1);
        mem(1'b1, 5'd3, 32'h31);
        expect_wr(5'd10, 32'hA1);
        tick();
        mem(1'b0, 5'd0, 32'h0);
        rs_addr = 5'd3;
        rt_addr = 5'd0;
        #1;
        chk("fwd_rs_hit", 32'(rs_hit), FWD ? 32'h1 : 32'h0);
        chk("fwd_rs_data", rs_fwd, FWD ? 32'h31 : 32'h0);
        chk("fwd_rt_zero_hit", 32'(rt_hit), 32'h0);
        chk("fwd_rt_zero_data", rt_fwd, 32'h0);
        rt_addr = 5'd10;
        #1;
        chk("fwd_outreg_hit", 32'(rt_hit), FWD ? 32'h1 : 32'h0);
        chk("fwd_outreg_data", rt_fwd, FWD ? 32'hA1 : 32'h0);
        alu(1'b1, 5'd3, 32'h33);
        expect_wr(5'd3, 32'h33);
        tick();
        chk("fwd_after_kill_hit", 32'(rs_hit), FWD ? 32'h1 : 32'h0);
        chk("fwd_after_kill_data", rs_fwd, FWD ? 32'h33 : 32'h0);
        chk("fwd_rt_miss", 32'(rt_hit), 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("fwd_killed_pop0", 32'(r_write), 32'h0);
        chk("fwd_dead_miss", 32'(rs_hit), 32'h0);
        tick();
        chk("fwd_killed_pop1", 32'(r_write), 32'h0);
        chk("fwd_count", 32'(fifo_count), 32'h0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;

        // ALU write to r0 is dropped and does not block the pop
        alu(1'b1, 5'd11, 32'hB0);
        mem(1'b1, 5'd2, 32'h22);
        expect_wr(5'd11, 32'hB0);
        tick();
        mem(1'b0, 5'd0, 32'h0);
        alu(1'b1, 5'd0, 32'hFFFF);
        expect_wr(5'd2, 32'h22);
        tick();
        chk("r0_pop_r_write", 32'(r_write), 32'h1);
        chk("r0_pop_count", 32'(fifo_count), 32'h0);
        alu(1'b0, 5'd0, 32'h0);

        // Reset with three entries queued discards them
        for (int i = 0; i < 3; i++) begin
            alu(1'b1, 5'd12, 32'hC0 + 32'(i));
            mem(1'b1, 5'(13 + i), 32'hD0 + 32'(i));
            expect_wr(5'd12, 32'hC0 + 32'(i));
            tick();
        end
        chk("pre_reset_count", 32'(fifo_count), 32'h3);
        reset = 1'b1;
        alu(1'b0, 5'd0, 32'h0);
        mem(1'b0, 5'd0, 32'h0);
        tick();
        chk("mid_rst_count", 32'(fifo_count), 32'h0);
        chk("mid_rst_r_write", 32'(r_write), 32'h0);
        chk("mid_rst_rd_addr", 32'(rd_addr), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_write", 32'(r_write), 32'h0);
        end
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
Drives the single write port (r_write / rd_addr / rd_w_data) of the processor register file, one commit per cycle. It merges a single-cycle ALU result stream with a buffered load/multi-cycle result stream, and enforces write ordering per register. It also supplies forwarding lookups so operand fetch sees pending writes that the register file does not yet hold.

Parameters:
ADDR, 5, register address width
BUS_W, 32, data width
DEPTH, 4, mem-result FIFO entries (power of 2, >=2)

Ports:
reloj_cucu  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU result present this cycle (no backpressure)
alu_addr  in  ADDR  ALU destination register
alu_data  in  BUS_W  ALU result
mem_valid  in  1  mem result offered
mem_ready  out  1  FIFO can accept (= !full)
mem_addr  in  ADDR  mem destination register
mem_data  in  BUS_W  mem result
r_write  out  1  register-file write enable (registered)
rd_addr  out  ADDR  write address (registered)
rd_w_data  out  BUS_W  write data (registered)
rs_addr  in  ADDR  lookup address A
rs_hit  out  1  pending write to rs_addr exists
rs_fwd  out  BUS_W  newest pending value for rs_addr
rt_addr  in  ADDR  lookup address B
rt_hit  out  1  pending write to rt_addr exists
rt_fwd  out  BUS_W  newest pending value for rt_addr
fifo_count  out  clog2(DEPTH)+1  occupied FIFO slots, live and killed

Behaviour:
- Reset, checked at the clock edge: r_write=0, rd_addr=0, rd_w_data=0, fifo_count=0, all entry valid bits 0, pointers 0. mem_ready=1 on the first cycle after reset.
- Mem push: happens when mem_valid && mem_ready. mem_ready depends only on registered count (count<DEPTH). A pop in the same cycle does not open space while full.
- Each FIFO entry holds {live, addr, data}. Pushed entries have live=1, except addr==0, which is pushed with live=0.
- Output stage, evaluated each cycle in priority order:
  1. alu_valid && alu_addr!=0: next r_write=1, rd_addr=alu_addr, rd_w_data=alu_data. FIFO does not pop.
  2. Else if FIFO non-empty: pop head. Next r_write=head.live, addr and data from head. A killed entry costs one cycle with r_write=0.
  3. Else: next r_write=0; rd_addr and rd_w_data hold their values.
- alu_valid with alu_addr==0 is dropped and does not block the pop. Register 0 is never written.
- Latency: ALU result reaches r_write 1 cycle after alu_valid. Mem result is committed at the earliest 1 cycle after push, if the FIFO was empty and no ALU write occurs that cycle.
- Ordering rule (ALU kill): an accepted ALU write to A clears live on every FIFO entry already stored with addr==A. An entry pushed in the same cycle as the ALU write is younger and is not killed.
- Starvation: continuous ALU traffic stalls the FIFO indefinitely. This is the intended behaviour; the pipeline guarantees gaps.
- Lookup (combinational), for each of rs/rt:
  - Hit on the youngest live FIFO entry with matching addr.
  - Else hit on the output register if r_write && rd_addr matches. That write commits at the next edge, and the RF read is asynchronous.
  - Address 0 never hits.
  - Same-cycle ALU and mem inputs are not searched; the producer stage forwards those itself.
  - On a miss, fwd=0.
- fifo_count includes killed entries.
- Reset mid-operation: pending entries are discarded, with no write issued for them.

Optional Feature:
RF_FWD_EN. When defined, the rs/rt lookup logic is present as described above. When undefined, rs_hit=rt_hit=0 and rs_fwd=rt_fwd=0, the search comparators are removed, and ports remain for interface stability. The ordering/kill logic is present in both builds.

Test Plan:
- Reset, then alu_valid=1, addr=5, data=0xDEAD_BEEF -> next cycle r_write=1, rd_addr=5, rd_w_data=0xDEADBEEF. All outputs are 0 during reset.
- Push 4 mem results (regs 1..4, data 0x11..0x44) with alu_valid held high to addr 9 -> mem_ready=0 after the 4th, fifo_count=4. On ALU release, commits occur to 1,2,3,4 on consecutive cycles.
- Push mem addr 7 data 0x70, then ALU addr 7 data 0x99 -> commit to 7 with 0x99, then a killed pop cycle with r_write=0. Final RF value is 0x99.
- Same cycle: mem push addr 6 data 0x60 and ALU addr 6 data 0x61 -> writes 0x61 then 0x60, in that order. Mem entry is not killed.
- RF_FWD_EN: FIFO holds addr 3 =0x30 then addr 3 =0x31, rs_addr=3 -> rs_hit=1, rs_fwd=0x31. rt_addr=0 -> rt_hit=0. Without the macro, both hits are 0.
- ALU addr 0 data 0xFFFF plus a pending mem entry to reg 2 -> no write to reg 0, and the mem entry commits that cycle. Reset asserted with 3 entries queued -> fifo_count=0 and no further writes.
